// File: rtl/mips_mem_pkg.sv
// Shared constants for the MEM-stage access path: access sizes, FSM state
// encodings and the alignment rule used by the optional misalignment trap.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_LOAD_WAIT = 2'b01;
  localparam logic [1:0] ST_RMW_MERGE = 2'b10;

  // Size 2'b11 is treated as a word access, so size[1] alone marks a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    if (size[1]) begin
      bad = (lo != 2'b00);
    end else if (size == SZ_HALF) begin
      bad = lo[0];
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word
// and merges byte/half store data into the old word for read-modify-write.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_s = rdata_i[{lane_i[1], 4'b0000} +: 16];

  // Load path: pick the lane and sign/zero extend it
  always_comb begin
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{byte_s[7] & ~unsigned_i}}, byte_s};
      SZ_HALF: load_data_o = {{16{half_s[15] & ~unsigned_i}}, half_s};
      default: load_data_o = rdata_i;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the old word
  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller for a one-cycle-latency word RAM: word stores in one
// cycle, loads and byte/half stores in two. Optional macro MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  misalign_err,
`endif
  output logic [4:0]            wb_rd
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  req_mis_s;
  logic [31:0]           load_s;
  logic [31:0]           merged_s;
  logic                  unused_s;

  // Upper address bits alias away by design.
  assign unused_s = ^{req_addr[31:ADDR_WIDTH+2]};

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign req_mis_s    = is_misaligned(req_size, req_addr[1:0]);
  assign misalign_err = mis_q;
`else
  assign req_mis_s = 1'b0;
`endif

  mem_lane_align u_align (
    .size_i      (size_q),
    .lane_i      (lane_q),
    .unsigned_i  (uns_q),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_s),
    .merged_o    (merged_s)
  );

  // Next-state, request capture and memory strobes
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d       = 1'b0;
`endif
    stall       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = idx_q;
    mem_wdata   = wdata_q;
    if (reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_address = req_addr[ADDR_WIDTH+1:2];
          mem_wdata   = req_wdata;
          if (req_valid && req_mis_s) begin
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d = 1'b1;
`endif
          end else if (req_valid && req_write && req_size[1]) begin
            mem_write = 1'b1;
          end else if (req_valid) begin
            mem_read = 1'b1;
            stall    = 1'b1;
            idx_d    = req_addr[ADDR_WIDTH+1:2];
            lane_d   = req_addr[1:0];
            size_d   = req_size;
            uns_d    = req_unsigned;
            wdata_d  = req_wdata;
            rd_d     = req_rd;
            state_d  = req_write ? ST_RMW_MERGE : ST_LOAD_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD_WAIT: begin
          wb_valid_d = 1'b1;
          wb_data_d  = load_s;
          wb_rd_d    = rd_q;
          state_d    = ST_IDLE;
        end
        ST_RMW_MERGE: begin
          mem_write = 1'b1;
          mem_wdata = merged_s;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and writeback registers; reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= {ADDR_WIDTH{1'b0}};
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0000_0000;
      wb_rd_q    <= 5'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;

endmodule
